// File: rtl/diag_out_scheduler.sv
// -----------------------------------------------------------------------------
// diag_out_scheduler
//
// Shares a small bank of diagnostic output pins between software and a set of
// hardware requesters. Software owns the pins by default (swPattern). When a
// requester is enabled and asks for the pins, a round-robin arbiter grants it
// ownership for a programmable number of cycles, after which the pins fall
// back to the software pattern. Software can abort a hold at any time by
// setting the override bit.
//
// Ports
//   sysClk        : single clock, rising edge
//   sysReset      : asynchronous, active-high reset
//   csrStrobe     : one-cycle CSR write strobe
//   GPIO_OUT      : CSR write data
//                     [OUTPUT_WIDTH-1:0] swPattern
//                     [4 +: REQ_COUNT]   enableMask
//                     [8]                override
//                     [31:16]            holdCycles
//   reqValid      : level request, one bit per requester
//   reqPattern    : requester i pattern in [i*OUTPUT_WIDTH +: OUTPUT_WIDTH]
//   reqGrant      : one-hot, one-cycle grant pulse
//   diagnosticOut : registered diagnostic pins
//   busy          : high while a requester owns the pins
//   status        : CSR readback
//                     [3:0] pins, [7:4] enableMask, [8] override, [9] busy,
//                     [11:10] owner index, [31:16] holdCycles
// -----------------------------------------------------------------------------
module diag_out_scheduler #(
  parameter int OUTPUT_WIDTH = 4,
  parameter int REQ_COUNT    = 4
) (
  input  logic                              sysClk,
  input  logic                              sysReset,
  input  logic                              csrStrobe,
  input  logic [31:0]                       GPIO_OUT,
  input  logic [REQ_COUNT-1:0]              reqValid,
  input  logic [REQ_COUNT*OUTPUT_WIDTH-1:0] reqPattern,
  output logic [REQ_COUNT-1:0]              reqGrant,
  output logic [OUTPUT_WIDTH-1:0]           diagnosticOut,
  output logic                              busy,
  output logic [31:0]                       status
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [OUTPUT_WIDTH-1:0]  swPattern_q;
  logic [REQ_COUNT-1:0]     enableMask_q;
  logic                     override_q;
  logic [15:0]              holdCycles_q;
  logic [15:0]              counter_q, counter_d;
  logic [OUTPUT_WIDTH-1:0]  diag_q, diag_d;
  logic [REQ_COUNT-1:0]     grant_q, grant_d;
  logic [1:0]               lastWinner_q, lastWinner_d;
  logic [1:0]               owner_q, owner_d;

  logic [OUTPUT_WIDTH-1:0]  swPatNext;
  logic                     overrideNext;
  logic [REQ_COUNT-1:0]     eligible;
  logic                     anyEligible;
  logic [1:0]               winnerIdx;
  logic [REQ_COUNT-1:0]     winnerOneHot;
  logic [OUTPUT_WIDTH-1:0]  winnerPattern;

  // Bits of GPIO_OUT outside the decoded fields are intentionally ignored.
  logic unusedCsrBits;
  assign unusedCsrBits = ^GPIO_OUT;

  // CSR fields are captured on the strobe and become visible to the
  // arbiter one cycle later.
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      swPattern_q  <= '0;
      enableMask_q <= '0;
      override_q   <= 1'b0;
      holdCycles_q <= '0;
    end else if (csrStrobe) begin
      swPattern_q  <= GPIO_OUT[OUTPUT_WIDTH-1:0];
      enableMask_q <= GPIO_OUT[4 +: REQ_COUNT];
      override_q   <= GPIO_OUT[8];
      holdCycles_q <= GPIO_OUT[31:16];
    end
  end

  // Look-ahead of the software pattern and override bit so that a write
  // shows up on the pins (or aborts a hold) on the cycle right after the
  // strobe rather than one cycle later.
  always_comb begin
    swPatNext    = csrStrobe ? GPIO_OUT[OUTPUT_WIDTH-1:0] : swPattern_q;
    overrideNext = csrStrobe ? GPIO_OUT[8] : override_q;
  end

  assign eligible = reqValid & enableMask_q & {REQ_COUNT{~override_q}};

  // Round-robin search. Offsets are walked from farthest to nearest so the
  // requester closest after lastWinner overwrites any earlier candidate.
  always_comb begin
    anyEligible   = 1'b0;
    winnerIdx     = '0;
    winnerOneHot  = '0;
    winnerPattern = '0;
    for (int k = REQ_COUNT; k >= 1; k--) begin
      for (int i = 0; i < REQ_COUNT; i++) begin
        if (eligible[i] && (((int'(lastWinner_q) + k) % REQ_COUNT) == i)) begin
          anyEligible = 1'b1;
          winnerIdx   = 2'(i);
        end
      end
    end
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (winnerIdx == 2'(i)) begin
        winnerOneHot[i] = anyEligible;
        winnerPattern   = reqPattern[i*OUTPUT_WIDTH +: OUTPUT_WIDTH];
      end
    end
  end

  // Next-state logic. A hold is never extended or shortened by CSR writes;
  // only the override bit can cut it short. The cycle a hold ends is always
  // spent returning to IDLE, so grants are separated by at least one cycle.
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    diag_d       = diag_q;
    grant_d      = '0;
    lastWinner_d = lastWinner_q;
    owner_d      = owner_q;
    case (state_q)
      IDLE: begin
        if (anyEligible) begin
          state_d      = HOLD;
          grant_d      = winnerOneHot;
          diag_d       = winnerPattern;
          counter_d    = (holdCycles_q == 16'd0) ? 16'd1 : holdCycles_q;
          lastWinner_d = winnerIdx;
          owner_d      = winnerIdx;
        end else begin
          diag_d = swPatNext;
        end
      end
      HOLD: begin
        if (overrideNext || (counter_q <= 16'd1)) begin
          state_d   = IDLE;
          diag_d    = swPatNext;
          counter_d = '0;
        end else begin
          counter_d = counter_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        diag_d  = swPatNext;
      end
    endcase
  end

  // Scheduler state register.
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      state_q      <= IDLE;
      counter_q    <= '0;
      diag_q       <= '0;
      grant_q      <= '0;
      lastWinner_q <= 2'(REQ_COUNT - 1);
      owner_q      <= '0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      diag_q       <= diag_d;
      grant_q      <= grant_d;
      lastWinner_q <= lastWinner_d;
      owner_q      <= owner_d;
    end
  end

  assign reqGrant      = grant_q;
  assign diagnosticOut = diag_q;
  assign busy          = (state_q == HOLD);

  // Readback is built purely from registers so it clears with reset
  // without waiting for a clock edge.
  always_comb begin
    status                      = '0;
    status[OUTPUT_WIDTH-1:0]    = diag_q;
    status[4 +: REQ_COUNT]      = enableMask_q;
    status[8]                   = override_q;
    status[9]                   = busy;
    status[11:10]               = owner_q;
    status[31:16]               = holdCycles_q;
  end

endmodule

// File: doc/diag_out_scheduler.md
DIAG_OUT_SCHEDULER -- requirements
Module: diag_out_scheduler

Interface
REQ-001 SHALL have parameter OUTPUT_WIDTH, default 4, giving the diagnostic output width (1..4).
REQ-002 SHALL have parameter REQ_COUNT, default 4, giving the number of hardware requesters (1..4).
REQ-003 SHALL have port sysClk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port sysReset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port csrStrobe, input, 1 bit: one-cycle CSR write strobe.
REQ-006 SHALL have port GPIO_OUT, input, 32 bits: CSR write data, sampled only when csrStrobe is high.
REQ-007 SHALL have port reqValid, input, REQ_COUNT bits: level request per requester.
REQ-008 SHALL have port reqPattern, input, REQ_COUNT*OUTPUT_WIDTH bits: requester i pattern in bits [i*OUTPUT_WIDTH +: OUTPUT_WIDTH].
REQ-009 SHALL have port reqGrant, output, REQ_COUNT bits: one-hot, one-cycle grant pulse.
REQ-010 SHALL have port diagnosticOut, output, OUTPUT_WIDTH bits: registered diagnostic pins.
REQ-011 SHALL have port busy, output, 1 bit: high while in HOLD.
REQ-012 SHALL have port status, output, 32 bits: CSR readback.

Function
REQ-013 SHALL decode the CSR write as follows:
- swPattern = GPIO_OUT[OUTPUT_WIDTH-1:0]
- enableMask = GPIO_OUT[4 +: REQ_COUNT]
- override = GPIO_OUT[8]
- holdCycles = GPIO_OUT[31:16]
REQ-014 SHALL take CSR values into effect the cycle after the strobe and SHALL NOT modify an in-progress hold, except as REQ-021 requires.
REQ-015 SHALL implement two states, IDLE and HOLD.
REQ-016 SHALL drive diagnosticOut = swPattern in IDLE, and update it within one cycle of a swPattern write.
REQ-017 SHALL treat requester i as eligible when reqValid[i] is high, enableMask[i] is high and override is low.
REQ-018 SHALL, in IDLE with any requester eligible at cycle N, at cycle N+1:
- pulse reqGrant for the winner
- drive diagnosticOut = winner's reqPattern as sampled at N
- load the counter with max(holdCycles, 1)
- enter HOLD
REQ-019 SHALL arbitrate round-robin:
- the search starts at index lastWinner+1, modulo REQ_COUNT
- lastWinner resets to REQ_COUNT-1, so requester 0 has first priority
REQ-020 SHALL, in HOLD:
- hold the latched pattern
- decrement the counter each cycle
- on the cycle the counter equals 1, return to IDLE, with swPattern driven on the next cycle
- so the granted pattern is driven exactly max(holdCycles,1) cycles
REQ-021 SHALL, when override becomes 1 during HOLD, abort to IDLE on the next cycle, driving swPattern.
REQ-022 SHALL NOT grant in the same cycle HOLD ends, so at least one IDLE cycle separates consecutive grants.
REQ-023 SHALL ignore reqValid and reqPattern changes while in HOLD; a requester keeping reqValid high after its grant is re-eligible in a later IDLE.
REQ-024 SHALL keep the current hold running when a requester is disabled or deasserts during HOLD.
REQ-025 SHALL drive status as follows:
- [3:0] diagnosticOut, zero-extended
- [7:4] enableMask, zero-extended
- [8] override
- [9] busy
- [11:10] current or last owner index
- [15:12] zero
- [31:16] holdCycles

Reset
REQ-026 SHALL, on sysReset asserted at any time including mid-HOLD, immediately set:
- state = IDLE
- diagnosticOut = 0, swPattern = 0, enableMask = 0, override = 0, holdCycles = 0
- reqGrant = 0, busy = 0, counter = 0
- lastWinner = REQ_COUNT-1, owner index = 0
REQ-027 SHALL resume arbitration on the first clock edge after sysReset deasserts.

Verification
REQ-028 SHALL be checked by these bench scenarios:
- Basic hold: write GPIO_OUT=0x0003_00F5, then hold reqValid=0001 with reqPattern[3:0]=0xA -> reqGrant=0001 for 1 cycle, diagnosticOut=0xA for exactly 3 cycles, then 0x5; busy high for those 3 cycles.
- Round-robin: holdCycles=1, enableMask=0xF, reqValid=1111 held -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
- Zero hold and masking: holdCycles=0 -> pattern held 1 cycle; reqValid=0100 with enableMask=0x3 -> no grant, diagnosticOut=swPattern.
- Override abort: during a hold with holdCycles=100, write bit8=1 -> next cycle diagnosticOut=swPattern and busy=0; no further grants while override=1.
- Reset mid-HOLD: assert sysReset asynchronously -> diagnosticOut=0, busy=0, status=0 without waiting for a clock edge.
- CSR during HOLD: change swPattern and holdCycles mid-hold -> current hold length unchanged; the new swPattern appears when the hold ends.
